// File: rtl/arm_pkg.sv
// Shared constants and types for the register-file writeback path.
package arm_pkg;

    localparam int REG_ADDR_W    = 4;
    localparam int DATA_W        = 32;
    localparam int PC_IDX        = 15;
    localparam int NUM_GPR       = 15;
    localparam int WB_FIFO_DEPTH = 4;

    // One pending writeback: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // One-hot register mask for a destination. The PC index has no GPR bit.
    function automatic logic [NUM_GPR-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
        logic [NUM_GPR-1:0] mask;
        if (dest == REG_ADDR_W'(PC_IDX)) begin
            mask = {NUM_GPR{1'b0}};
        end else begin
            mask = NUM_GPR'(1) << dest;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: {dest,data} storage, wrapping pointers and occupancy
// count, plus a per-entry valid/dest view used for pending-register tracking.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wb_entry_t                            wr_entry,
    input  logic                                 pop,
    output wb_entry_t                            rd_entry,
    output logic [CNT_W-1:0]                     count,
    output logic [DEPTH-1:0]                     ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_dest
);

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic [PTR_W-1:0]   offs_s [DEPTH];

    // Guard against overflow/underflow regardless of what the caller requests.
    always_comb begin
        push_ok_s = push && (count_r < CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    end

    // Entry storage; cleared on reset so no stale data survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

    // Pointer and count update; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs_s[i]    = PTR_W'(i) - rd_ptr_r;
            ent_valid[i] = ({1'b0, offs_s[i]} < count_r);
            ent_dest[i]  = mem_r[i].dest;
        end
    end

    assign rd_entry = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU writes take priority, buffered load
// results drain from a FIFO when the ALU is idle. Writes to the PC index are
// discarded and flagged with a one-cycle pulse.
module wb_arbiter
    import arm_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wr_en,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  mem_wr_valid,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_wr_ready,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0]     wb_data,
    output logic [NUM_GPR-1:0]    pend_mask,
    output logic                  stall,
    output logic                  pc_wr_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]                 count_s;
    logic                             push_s;
    logic                             pop_s;
    logic                             sel_valid_s;
    wb_entry_t                        sel_entry_s;
    wb_entry_t                        head_s;
    wb_entry_t                        push_entry_s;
    logic [DEPTH-1:0]                 ent_valid_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dest_s;
    logic [NUM_GPR-1:0]               pend_mask_s;
    logic                             ready_s;
    logic                             full_s;

    logic                             wb_en_r;
    logic [REG_ADDR_W-1:0]            wb_dest_r;
    logic [DATA_W-1:0]                wb_data_r;
    logic                             pc_wr_drop_r;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .wr_entry  (push_entry_s),
        .pop       (pop_s),
        .rd_entry  (head_s),
        .count     (count_s),
        .ent_valid (ent_valid_s),
        .ent_dest  (ent_dest_s)
    );

    // Flow control from the registered count; a full FIFO refuses even if it pops.
    always_comb begin
        ready_s           = (count_s < CNT_W'(DEPTH));
        full_s            = (count_s == CNT_W'(DEPTH));
        push_s            = mem_wr_valid && ready_s;
        push_entry_s.dest = mem_dest;
        push_entry_s.data = mem_data;
    end

    // Source select: ALU first, then FIFO head; the FIFO pops only when chosen.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_entry_s = '0;
        pop_s       = 1'b0;
        if (alu_wr_en) begin
            sel_valid_s      = 1'b1;
            sel_entry_s.dest = alu_dest;
            sel_entry_s.data = alu_result;
        end else if (count_s != {CNT_W{1'b0}}) begin
            sel_valid_s = 1'b1;
            sel_entry_s = head_s;
            pop_s       = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Registers with an outstanding load: OR of live entries' one-hot dests.
    always_comb begin
        pend_mask_s = {NUM_GPR{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_s[i]) begin
                pend_mask_s = pend_mask_s | dest_onehot(ent_dest_s[i]);
            end else begin
                pend_mask_s = pend_mask_s;
            end
        end
    end

    // Writeback output register; PC-index writes become a drop pulse instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_r      <= 1'b0;
            wb_dest_r    <= {REG_ADDR_W{1'b0}};
            wb_data_r    <= {DATA_W{1'b0}};
            pc_wr_drop_r <= 1'b0;
        end else if (sel_valid_s && (sel_entry_s.dest == REG_ADDR_W'(PC_IDX))) begin
            wb_en_r      <= 1'b0;
            pc_wr_drop_r <= 1'b1;
        end else if (sel_valid_s) begin
            wb_en_r      <= 1'b1;
            wb_dest_r    <= sel_entry_s.dest;
            wb_data_r    <= sel_entry_s.data;
            pc_wr_drop_r <= 1'b0;
        end else begin
            wb_en_r      <= 1'b0;
            pc_wr_drop_r <= 1'b0;
        end
    end

    assign mem_wr_ready = ready_s;
    assign stall        = full_s;
    assign pend_mask    = pend_mask_s;
    assign wb_en        = wb_en_r;
    assign wb_dest      = wb_dest_r;
    assign wb_data      = wb_data_r;
    assign pc_wr_drop   = pc_wr_drop_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wr_en;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        mem_wr_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_data;
    logic        mem_wr_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [14:0] pend_mask;
    logic        stall;
    logic        pc_wr_drop;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wr_en    (alu_wr_en),
        .alu_dest     (alu_dest),
        .alu_result   (alu_result),
        .mem_wr_valid (mem_wr_valid),
        .mem_dest     (mem_dest),
        .mem_data     (mem_data),
        .mem_wr_ready (mem_wr_ready),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .pend_mask    (pend_mask),
        .stall        (stall),
        .pc_wr_drop   (pc_wr_drop)
    );

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          checks   = 0;
    int          failures = 0;
    logic        exp_en;
    logic        exp_drop;
    logic [3:0]  exp_dest;
    logic [31:0] exp_data;

    // Pending-register set derived from the model queue contents.
    function automatic logic [14:0] model_pend();
        logic [14:0] m;
        m = 15'd0;
        foreach (mq[i]) begin
            if (mq[i].dest != 4'd15) m[mq[i].dest] = 1'b1;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, exp_en});
        if (exp_en) begin
            chk({tag, ".wb_dest"}, {28'd0, wb_dest}, {28'd0, exp_dest});
            chk({tag, ".wb_data"}, wb_data, exp_data);
        end
        chk({tag, ".pc_wr_drop"}, {31'd0, pc_wr_drop}, {31'd0, exp_drop});
        chk({tag, ".mem_wr_ready"}, {31'd0, mem_wr_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".stall"}, {31'd0, stall}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".pend_mask"}, {17'd0, pend_mask}, {17'd0, model_pend()});
    endtask

    task automatic drive(input logic ae, input logic [3:0] ad, input logic [31:0] ar,
                         input logic mv, input logic [3:0] md, input logic [31:0] mdat);
        alu_wr_en    = ae;
        alu_dest     = ad;
        alu_result   = ar;
        mem_wr_valid = mv;
        mem_dest     = md;
        mem_data     = mdat;
    endtask

    // Advance one clock from a negedge, updating the model from the arbitration rules.
    task automatic step(input string tag);
        bit   ready;
        bit   sel;
        ent_t e;
        ready    = (mq.size() < DEPTH);
        sel      = 1'b0;
        exp_en   = 1'b0;
        exp_drop = 1'b0;
        if (alu_wr_en) begin
            e.dest = alu_dest;
            e.data = alu_result;
            sel    = 1'b1;
        end else if (mq.size() > 0) begin
            e   = mq.pop_front();
            sel = 1'b1;
        end
        if (sel) begin
            if (e.dest == 4'd15) begin
                exp_drop = 1'b1;
            end else begin
                exp_en   = 1'b1;
                exp_dest = e.dest;
                exp_data = e.data;
            end
        end
        if (mem_wr_valid && ready) begin
            e.dest = mem_dest;
            e.data = mem_data;
            mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        step(tag);
    endtask

    initial begin
        int          d;
        logic [14:0] pm;

        rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        exp_en   = 1'b0;
        exp_drop = 1'b0;
        exp_dest = 4'd0;
        exp_data = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst.wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst.wb_dest", {28'd0, wb_dest}, 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.pc_wr_drop", {31'd0, pc_wr_drop}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.pend_mask", {17'd0, pend_mask}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.mem_wr_ready", {31'd0, mem_wr_ready}, 32'd1);
        @(negedge clk);

        // ALU-only write
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        step("alu_only");
        chk("alu_only.dest", {28'd0, wb_dest}, 32'd3);
        chk("alu_only.data", wb_data, 32'hDEADBEEF);
        idle("alu_only.idle");

        // Collision: ALU holds priority over a buffered load
        drive(1'b1, 4'd2, 32'h22, 1'b1, 4'd5, 32'h55);
        step("coll.c1");
        chk("coll.c1.dest", {28'd0, wb_dest}, 32'd2);
        chk("coll.c1.pend5", {31'd0, pend_mask[5]}, 32'd1);
        drive(1'b1, 4'd2, 32'h23, 1'b0, 4'd0, 32'd0);
        step("coll.c2");
        chk("coll.c2.pend5", {31'd0, pend_mask[5]}, 32'd1);
        idle("coll.c3");
        chk("coll.c3.dest", {28'd0, wb_dest}, 32'd5);
        chk("coll.c3.data", wb_data, 32'h55);
        chk("coll.c3.pend5", {31'd0, pend_mask[5]}, 32'd0);

        // Fill to full while the ALU keeps the port busy, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'd9, 32'h900 + 32'(i), 1'b1, 4'(i), 32'hA0 + 32'(i));
            step("fill.push");
        end
        chk("fill.stall", {31'd0, stall}, 32'd1);
        chk("fill.ready", {31'd0, mem_wr_ready}, 32'd0);
        drive(1'b1, 4'd9, 32'h999, 1'b1, 4'd7, 32'h77);
        step("fill.blocked");
        for (int i = 1; i <= 4; i++) begin
            idle("fill.drain");
            chk("fill.drain.dest", {28'd0, wb_dest}, 32'(i));
            chk("fill.drain.en", {31'd0, wb_en}, 32'd1);
        end
        chk("fill.stall_clear", {31'd0, stall}, 32'd0);
        idle("fill.empty");

        // Simultaneous push and pop at count 2
        drive(1'b1, 4'd9, 32'h1, 1'b1, 4'd6, 32'h66);
        step("pp.a");
        drive(1'b1, 4'd9, 32'h2, 1'b1, 4'd7, 32'h77);
        step("pp.b");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 32'h88);
        step("pp.both");
        chk("pp.both.dest", {28'd0, wb_dest}, 32'd6);
        chk("pp.both.pend", {17'd0, pend_mask}, 32'h180);
        idle("pp.d7");
        chk("pp.d7.dest", {28'd0, wb_dest}, 32'd7);
        idle("pp.d8");
        chk("pp.d8.dest", {28'd0, wb_dest}, 32'd8);
        idle("pp.empty");

        // Load to the PC index is dropped but still pops
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h1234);
        step("pc.push");
        idle("pc.pop");
        chk("pc.pop.wb_en", {31'd0, wb_en}, 32'd0);
        chk("pc.pop.drop", {31'd0, pc_wr_drop}, 32'd1);
        idle("pc.after");
        chk("pc.after.drop", {31'd0, pc_wr_drop}, 32'd0);

        // Reset with three loads pending
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'd10, 32'hB0 + 32'(i), 1'b1, 4'(i), 32'hC0 + 32'(i));
            step("rstp.fill");
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        rst = 1'b1;
        #1;
        mq.delete();
        exp_en   = 1'b0;
        exp_drop = 1'b0;
        chk("rstp.wb_en", {31'd0, wb_en}, 32'd0);
        chk("rstp.pend", {17'd0, pend_mask}, 32'd0);
        chk("rstp.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstp.ready", {31'd0, mem_wr_ready}, 32'd1);
        @(negedge clk);
        idle("rstp.idle1");
        idle("rstp.idle2");

        // Random traffic; ALU never targets a register with a pending load
        for (int n = 0; n < 400; n++) begin
            pm = model_pend();
            do begin
                d = int'($urandom_range(0, 15));
            end while (d != 15 && pm[d]);
            drive(($urandom_range(0, 2) == 0), 4'(d), $urandom,
                  ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom);
            step("rand");
        end
        for (int n = 0; n < DEPTH + 1; n++) begin
            idle("rand.drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
